pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: stall watchdog counter width.
REQ-002 Parameter WDOG_MAX, default 255: consecutive-stall cycle count that trips the watchdog; SHALL be at most 2^CNT_W-1.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 pause_req_if  input  1: IF stage stall request, level.
REQ-006 pause_req_id  input  1: ID stage stall request, level (load-use hazard).
REQ-007 pause_req_ex  input  1: EX stage stall request, level (multi-cycle ALU op).
REQ-008 pause_req_mem  input  1: MEM stage stall request, level (memory access outstanding).
REQ-009 excp_valid  input  1: MEM stage reports an exception or redirect this cycle.
REQ-010 excp_target  input  32: redirect PC, sampled when excp_valid is accepted.
REQ-011 pause  output  6: stall vector to the pipeline registers; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-012 flush  output  1: clear all pipeline registers this cycle.
REQ-013 new_pc  output  32: redirect target; valid while new_pc_valid=1.
REQ-014 new_pc_valid  output  1: PC SHALL load new_pc this cycle.
REQ-015 stall_timeout  output  1: sticky watchdog flag.

Function
REQ-016 Controller SHALL implement a three-state FSM: RUN, DRAIN, FLUSH.
REQ-017 In RUN, pause SHALL be combinational from the highest-index active request: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
REQ-018 pause[5] SHALL be 0 in all states, so WB never stalls.
REQ-019 Thus the stage just above the highest stalled stage sees a 0 bit and inserts a bubble (e.g. pause[3]=1, pause[4]=0 -> MEM receives NOP).
REQ-020 RUN with excp_valid=1 and pause_req_mem=0: capture excp_target; next state FLUSH.
REQ-021 RUN with excp_valid=1 and pause_req_mem=1: capture excp_target; next state DRAIN.
REQ-022 In the exception-accept cycle, pause SHALL follow the REQ-017 decode.
REQ-023 In DRAIN, pause SHALL be 6'b011111 regardless of other requests; excp_valid SHALL be ignored.
REQ-024 DRAIN SHALL go to FLUSH on the first cycle pause_req_mem=0.
REQ-025 In FLUSH: flush=1, new_pc_valid=1, new_pc=captured target, pause=6'b000000.
REQ-026 FLUSH SHALL last exactly one cycle and then go to RUN unconditionally.
REQ-027 excp_valid and all pause requests SHALL be ignored during FLUSH.
REQ-028 flush and new_pc_valid SHALL be Moore outputs, decoded from state only, and 0 outside FLUSH.
REQ-029 new_pc SHALL hold the last captured target at all times; it is meaningful only in FLUSH.
REQ-030 Latency from excp_valid accept (no mem stall) to flush=1 SHALL be exactly 1 cycle.
REQ-031 stall counter, CNT_W bits: increments each cycle pause!=0, saturating at WDOG_MAX; clears to 0 on any cycle pause==0.
REQ-032 stall_timeout SHALL set on the edge where the counter reaches WDOG_MAX and SHALL stay set until reset.
REQ-033 Requests that change mid-stall SHALL re-decode combinationally the same cycle; the controller SHALL add no stall cycles of its own.

Reset
REQ-034 rst=1 SHALL immediately force: state RUN, captured target 32'h0, stall counter 0, stall_timeout 0, flush 0, new_pc_valid 0, new_pc 32'h0.
REQ-035 While rst=1, pause SHALL be 6'b000000 regardless of requests.
REQ-036 Reset asserted in DRAIN or FLUSH SHALL abandon the pending redirect; no flush pulse SHALL follow reset release.

Verification
REQ-037 pause_req_ex=1 and pause_req_if=1 for 3 cycles -> pause=6'b001111 for those 3 cycles, then 6'b000000; flush stays 0.
REQ-038 excp_valid=1, excp_target=32'h1c000100, no stalls -> next cycle flush=1, new_pc_valid=1, new_pc=32'h1c000100 for exactly one cycle; then RUN.
REQ-039 excp_valid=1 with pause_req_mem=1 held 4 more cycles -> DRAIN with pause=6'b011111 and new excp_valid ignored; flush=1 in the cycle after pause_req_mem falls.
REQ-040 pause_req_id held 300 cycles with WDOG_MAX=255 -> stall_timeout rises at stall cycle 255 and stays 1 after pause_req_id drops.
REQ-041 rst pulsed mid-cycle while in DRAIN -> outputs clear at once without waiting for clk; no flush after release.
REQ-042 excp_valid=1 in the FLUSH cycle -> ignored; exactly one flush pulse, carrying the first target.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stages and the pipeline controller.
// master: the pipeline side, which raises the requests and consumes stall/flush/redirect.
// slave : the controller side.
interface pipeline_ctrl_if;
  logic        pause_req_if;
  logic        pause_req_id;
  logic        pause_req_ex;
  logic        pause_req_mem;
  logic        excp_valid;
  logic [31:0] excp_target;
  logic [5:0]  pause;
  logic        flush;
  logic [31:0] new_pc;
  logic        new_pc_valid;
  logic        stall_timeout;

  modport master (
    output pause_req_if, pause_req_id, pause_req_ex, pause_req_mem,
    output excp_valid, excp_target,
    input  pause, flush, new_pc, new_pc_valid, stall_timeout
  );

  modport slave (
    input  pause_req_if, pause_req_id, pause_req_ex, pause_req_mem,
    input  excp_valid, excp_target,
    output pause, flush, new_pc, new_pc_valid, stall_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller.
// Stalls every stage up to and including the deepest requesting stage, so the
// stage just below it receives a bubble. An exception reported by MEM waits in
// DRAIN until MEM's outstanding access completes, then a single FLUSH cycle
// clears the pipeline and redirects the PC. A sticky watchdog flags stalls that
// last WDOG_MAX consecutive cycles.
module pipeline_ctrl #(
  parameter int CNT_W    = 8,
  parameter int WDOG_MAX = 255
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WDOG_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [31:0]      target_reg, target_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;
  logic [5:0]       pause_run;
  logic [5:0]       pause_comb;

  // Priority decode of the stall requests: deepest requesting stage wins.
  always_comb begin
    pause_run = 6'b000000;
    if (bus.pause_req_mem)
      pause_run = 6'b011111;
    else if (bus.pause_req_ex)
      pause_run = 6'b001111;
    else if (bus.pause_req_id)
      pause_run = 6'b000111;
    else if (bus.pause_req_if)
      pause_run = 6'b000011;
  end

  // FSM next state, redirect capture and stall vector selection.
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    pause_comb  = 6'b000000;
    case (state_reg)
      ST_RUN: begin
        pause_comb = pause_run;
        if (bus.excp_valid) begin
          target_next = bus.excp_target;
          state_next  = bus.pause_req_mem ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        // Hold everything up to MEM until its access finishes; new exceptions are ignored.
        pause_comb = 6'b011111;
        if (!bus.pause_req_mem)
          state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Watchdog: count consecutive stalled cycles, saturating; the flag is sticky.
  always_comb begin
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    if (pause_comb == 6'b000000)
      cnt_next = '0;
    else if (cnt_reg < CNT_LIM)
      cnt_next = cnt_reg + CNT_ONE;
    if (cnt_next == CNT_LIM)
      timeout_next = 1'b1;
  end

  // State, captured target and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      target_reg  <= 32'h0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      target_reg  <= target_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  // Reset masks the stall vector immediately; flush/redirect are pure state decodes.
  assign bus.pause         = rst ? 6'b000000 : pause_comb;
  assign bus.flush         = (state_reg == ST_FLUSH);
  assign bus.new_pc_valid  = (state_reg == ST_FLUSH);
  assign bus.new_pc        = target_reg;
  assign bus.stall_timeout = timeout_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a cycle-level behavioural model
// compared on every falling edge, plus hand-computed literal expectations.
module tb_pipeline_ctrl;

  localparam int WDOG = 255;

  logic clk;
  logic rst;
  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.CNT_W(8), .WDOG_MAX(WDOG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: pending redirect waiting for MEM, flush due this cycle,
  // last accepted target, length of current stall run, sticky watchdog flag.
  bit          m_waiting_mem;
  bit          m_flush_now;
  logic [31:0] m_target;
  int          m_stall_run;
  bit          m_timeout;

  // Outputs sampled during the latest tick.
  logic [5:0]  s_pause;
  logic        s_flush;
  logic        s_npv;
  logic [31:0] s_npc;
  logic        s_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_waiting_mem = 1'b0;
    m_flush_now   = 1'b0;
    m_target      = 32'h0;
    m_stall_run   = 0;
    m_timeout     = 1'b0;
  endtask

  task automatic set_req(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem,
                         input logic ev, input logic [31:0] tgt);
    bus.pause_req_if  = r_if;
    bus.pause_req_id  = r_id;
    bus.pause_req_ex  = r_ex;
    bus.pause_req_mem = r_mem;
    bus.excp_valid    = ev;
    bus.excp_target   = tgt;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    int          top;
    logic [5:0]  exp_pause;
    bit          n_wait;
    bit          n_flush;
    logic [31:0] n_tgt;
    int          n_run;
    @(negedge clk);
    s_pause = bus.pause;
    s_flush = bus.flush;
    s_npv   = bus.new_pc_valid;
    s_npc   = bus.new_pc;
    s_to    = bus.stall_timeout;

    if (m_flush_now)
      exp_pause = 6'b000000;
    else if (m_waiting_mem)
      exp_pause = 6'b011111;
    else begin
      top = 0;
      if (bus.pause_req_if)  top = 1;
      if (bus.pause_req_id)  top = 2;
      if (bus.pause_req_ex)  top = 3;
      if (bus.pause_req_mem) top = 4;
      exp_pause = (top == 0) ? 6'b000000 : 6'((1 << (top + 1)) - 1);
    end

    chk("pause",         32'(s_pause), 32'(exp_pause));
    chk("flush",         32'(s_flush), 32'(m_flush_now));
    chk("new_pc_valid",  32'(s_npv),   32'(m_flush_now));
    chk("new_pc",        s_npc,        m_target);
    chk("stall_timeout", 32'(s_to),    32'(m_timeout));

    n_wait  = m_waiting_mem;
    n_flush = 1'b0;
    n_tgt   = m_target;
    if (m_flush_now) begin
      n_wait = 1'b0;
    end else if (m_waiting_mem) begin
      if (!bus.pause_req_mem) begin
        n_wait  = 1'b0;
        n_flush = 1'b1;
      end
    end else if (bus.excp_valid) begin
      n_tgt = bus.excp_target;
      if (bus.pause_req_mem) n_wait = 1'b1;
      else                   n_flush = 1'b1;
    end
    if (exp_pause != 6'b000000)
      n_run = (m_stall_run < WDOG) ? m_stall_run + 1 : m_stall_run;
    else
      n_run = 0;

    @(posedge clk);
    m_waiting_mem = n_wait;
    m_flush_now   = n_flush;
    m_target      = n_tgt;
    m_stall_run   = n_run;
    if (n_run == WDOG) m_timeout = 1'b1;
    #1;
  endtask

  initial begin
    // Reset with requests active: stall vector must stay clear.
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hffff_0000);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("rst_pause", 32'(bus.pause),         32'h0);
      chk("rst_flush", 32'(bus.flush),         32'h0);
      chk("rst_npv",   32'(bus.new_pc_valid),  32'h0);
      chk("rst_npc",   bus.new_pc,             32'h0);
      chk("rst_to",    32'(bus.stall_timeout), 32'h0);
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tick();

    // EX + IF stall for 3 cycles.
    set_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) begin
      tick();
      chk("ex_if_pause", 32'(s_pause), 32'h0f);
      chk("ex_if_flush", 32'(s_flush), 32'h0);
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("ex_if_release", 32'(s_pause), 32'h0);

    // Single-cycle priority decodes.
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick(); chk("if_pause",  32'(s_pause), 32'h03);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick(); chk("id_pause",  32'(s_pause), 32'h07);
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0); tick(); chk("mem_pause", 32'(s_pause), 32'h1f);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();

    // Exception with no stall: flush one cycle later.
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1c00_0100);
    tick();
    chk("excp_accept_flush", 32'(s_flush), 32'h0);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("excp_flush", 32'(s_flush), 32'h1);
    chk("excp_npv",   32'(s_npv),   32'h1);
    chk("excp_npc",   s_npc,        32'h1c00_0100);
    tick();
    chk("excp_one_pulse", 32'(s_flush), 32'h0);

    // Exception accepted while EX stalls: pause follows the decode that cycle.
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_8000);
    tick();
    chk("excp_ex_pause", 32'(s_pause), 32'h0f);
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("excp_ex_flush", 32'(s_flush), 32'h1);
    chk("excp_ex_pause_flush", 32'(s_pause), 32'h0);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Exception while MEM busy: drain, ignore new exceptions, flush after MEM releases.
    set_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000_0040);
    tick();
    chk("drain_accept_pause", 32'(s_pause), 32'h1f);
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 1'b1, 1'b0, 1'b1, (i % 2) == 0, 32'hdead_0000 + 32'(i));
      tick();
      chk("drain_pause", 32'(s_pause), 32'h1f);
      chk("drain_flush", 32'(s_flush), 32'h0);
    end
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("drain_last_pause", 32'(s_pause), 32'h1f);
    chk("drain_last_flush", 32'(s_flush), 32'h0);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("drain_flush_pulse", 32'(s_flush), 32'h1);
    chk("drain_flush_npc",   s_npc,        32'h2000_0040);
    tick();
    chk("drain_after", 32'(s_flush), 32'h0);

    // Exception during FLUSH is ignored.
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000_0000);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0000);
    tick();
    chk("flush_ignore_pulse", 32'(s_flush), 32'h1);
    chk("flush_ignore_npc",   s_npc,        32'h3000_0000);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("flush_ignore_no2nd", 32'(s_flush), 32'h0);
    chk("flush_ignore_hold",  s_npc,        32'h3000_0000);
    tick();
    chk("flush_ignore_no3rd", 32'(s_flush), 32'h0);

    // Watchdog: ID stall for 300 cycles.
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 255) chk("wdog_before", 32'(s_to), 32'h0);
      if (i == 256) chk("wdog_trip",   32'(s_to), 32'h1);
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    chk("wdog_sticky", 32'(s_to), 32'h1);

    // Asynchronous reset while draining: outputs clear at once, redirect is abandoned.
    set_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5000_0000);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("pre_rst_pause", 32'(s_pause), 32'h1f);
    #1 rst = 1'b1;
    #1;
    chk("arst_pause", 32'(bus.pause),         32'h0);
    chk("arst_flush", 32'(bus.flush),         32'h0);
    chk("arst_npv",   32'(bus.new_pc_valid),  32'h0);
    chk("arst_npc",   bus.new_pc,             32'h0);
    chk("arst_to",    32'(bus.stall_timeout), 32'h0);
    #1 rst = 1'b0;
    model_reset();
    tick();
    chk("post_rst_mem_pause", 32'(s_pause), 32'h1f);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) begin
      tick();
      chk("post_rst_no_flush", 32'(s_flush), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
